// File: rtl/spi_byte_master_pkg.sv
// Shared constants for the SPI byte master: byte width, default divider and
// the 2-bit state encodings used by spi_byte_master and spi_mode_config.
package spi_byte_master_pkg;

  localparam int unsigned SPI_BITS            = 8;
  localparam int unsigned SPI_CLK_DIV_DEFAULT = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/spi_byte_master_if.sv
// Byte command/response bus between spi_mode_config (master side) and
// spi_byte_master (slave side).
interface spi_byte_master_if;
  import spi_byte_master_pkg::*;

  logic                start;
  logic [SPI_BITS-1:0] byte_in;
  logic                busy;
  logic                done;
  logic [SPI_BITS-1:0] byte_out;

  modport master (output start, output byte_in,
                  input  busy,  input  done, input byte_out);
  modport slave  (input  start, input  byte_in,
                  output busy,  output done, output byte_out);

endinterface

// File: rtl/spi_byte_master_clk_div.sv
// Half-period counter: counts 0..CLK_DIV-1 while enabled and emits a one-cycle
// tick on the terminal count; held at zero while disabled.
module spi_clk_div #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (!en || tick) cnt_d = '0;
    else             cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_byte_master.sv
// Mode-0 (CPOL=0, CPHA=0) MSB-first SPI byte master.
// Optional: define SPI_LOOPBACK_EN to add a loopback input sampling mosi instead of miso.
module spi_byte_master
  import spi_byte_master_pkg::*;
#(
  parameter int unsigned CLK_DIV = SPI_CLK_DIV_DEFAULT,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  spi_byte_master_if.slave   bus,
`ifdef SPI_LOOPBACK_EN
  input  logic               loopback,
`endif
  input  logic               miso,
  output logic               sclk,
  output logic               mosi
);

  logic [1:0]          state_q, state_d;
  logic [SPI_BITS-1:0] tx_sr_q, tx_sr_d;
  logic [SPI_BITS-1:0] rx_sr_q, rx_sr_d;
  logic [SPI_BITS-1:0] byte_out_q, byte_out_d;
  logic [2:0]          bitcnt_q, bitcnt_d;
  logic                active;
  logic                tick;
  logic                sample;

  assign active = (state_q == ST_LOW) || (state_q == ST_HIGH);

`ifdef SPI_LOOPBACK_EN
  assign sample = loopback ? mosi : miso;
`else
  assign sample = miso;
`endif

  spi_clk_div #(.CLK_DIV(CLK_DIV), .CNT_W(CNT_W)) u_clk_div (
    .clk  (clk),
    .rst  (rst),
    .en   (active),
    .tick (tick)
  );

  always_comb begin
    state_d    = state_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    byte_out_d = byte_out_q;
    bitcnt_d   = bitcnt_q;
    case (state_q)
      // DONE accepts a new start exactly like IDLE for back-to-back bytes
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (bus.start) begin
          tx_sr_d  = bus.byte_in;
          rx_sr_d  = '0;
          bitcnt_d = 3'd7;
          state_d  = ST_LOW;
        end
      end
      ST_LOW: begin
        if (tick) begin
          rx_sr_d = {rx_sr_q[SPI_BITS-2:0], sample};
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (tick) begin
          if (bitcnt_q != 3'd0) begin
            bitcnt_d = bitcnt_q - 3'd1;
            tx_sr_d  = {tx_sr_q[SPI_BITS-2:0], 1'b0};
            state_d  = ST_LOW;
          end else begin
            byte_out_d = rx_sr_q;
            state_d    = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      byte_out_q <= '0;
      bitcnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      byte_out_q <= byte_out_d;
      bitcnt_q   <= bitcnt_d;
    end
  end

  assign sclk         = (state_q == ST_HIGH);
  assign mosi         = active && tx_sr_q[SPI_BITS-1];
  assign bus.busy     = active;
  assign bus.done     = (state_q == ST_DONE);
  assign bus.byte_out = byte_out_q;

endmodule

// File: tb/tb_spi_byte_master.sv
// Directed bench for spi_byte_master: per-cycle comparison against a
// transfer-timeline model plus literal checks of the headline scenarios.
module tb_spi_byte_master;
  import spi_byte_master_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int XFER    = 16 * CLK_DIV;
  localparam int BITLEN  = 2 * CLK_DIV;

  logic clk = 1'b0;
  logic rst;
  logic miso;
  logic sclk;
  logic mosi;
`ifdef SPI_LOOPBACK_EN
  logic loopback;
`endif

  spi_byte_master_if bus ();

  spi_byte_master #(.CLK_DIV(CLK_DIV), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
`ifdef SPI_LOOPBACK_EN
    .loopback (loopback),
`endif
    .miso     (miso),
    .sclk     (sclk),
    .mosi     (mosi)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  bit         m_active = 1'b0;
  int         m_t0     = 0;
  logic [7:0] m_tx     = '0;
  logic [7:0] m_rx     = '0;
  logic [7:0] m_bo     = '0;
  bit         m_lb     = 1'b0;
  logic [7:0] slave_byte = '0;
  bit         tie_miso0  = 1'b0;

  logic       prev_sclk = 1'b0;
  int         rises     = 0;
  int         busy_cnt  = 0;
  logic [7:0] mosi_cap  = '0;
  int         done_cycles[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit lb_now();
`ifdef SPI_LOOPBACK_EN
    return loopback;
`else
    return 1'b0;
`endif
  endfunction

  // One clock cycle: compare outputs for this cycle, then drive inputs for it.
  task automatic step(input logic st, input logic [7:0] b);
    int   k;
    int   idx;
    logic e_sclk, e_mosi, e_busy, e_done;
    @(posedge clk);
    #1;
    cyc++;
    k = m_active ? (cyc - m_t0) : -1;
    if (m_active && k > XFER + 1) begin
      m_active = 1'b0;
      k = -1;
    end
    e_busy = (k >= 1) && (k <= XFER);
    e_done = (k == XFER + 1);
    idx    = e_busy ? 7 - ((k - 1) / BITLEN) : 0;
    e_sclk = e_busy && (((k - 1) / CLK_DIV) % 2 == 1);
    e_mosi = e_busy && m_tx[idx];
    if (e_done) m_bo = m_lb ? m_tx : m_rx;

    chk("sclk",     sclk,         e_sclk);
    chk("mosi",     mosi,         e_mosi);
    chk("busy",     bus.busy,     e_busy);
    chk("done",     bus.done,     e_done);
    chk("byte_out", bus.byte_out, m_bo);

    if (sclk && !prev_sclk) begin
      rises++;
      mosi_cap = {mosi_cap[6:0], mosi};
    end
    prev_sclk = sclk;
    if (bus.busy) busy_cnt++;
    if (bus.done) done_cycles.push_back(cyc);

    bus.start   = st;
    bus.byte_in = b;
    miso = (e_busy && !tie_miso0) ? m_rx[idx] : 1'b0;
    if (st && (!m_active || e_done)) begin
      m_active = 1'b1;
      m_t0     = cyc;
      m_tx     = b;
      m_rx     = slave_byte;
      m_lb     = lb_now();
      rises    = 0;
      busy_cnt = 0;
      mosi_cap = '0;
    end
  endtask

  int s0;
  int ndone;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.byte_in = '0;
    miso = 1'b0;
`ifdef SPI_LOOPBACK_EN
    loopback = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_byte_out", bus.byte_out, 8'h00);
    rst = 1'b0;

    // Clock idle after reset
    repeat (100) step(1'b0, 8'h00);

    // Basic TX/RX
    slave_byte = 8'h3C;
    step(1'b1, 8'hA5);
    s0 = cyc;
    repeat (XFER + 1) step(1'b0, 8'h00);
    chk("basic_mosi_bits", mosi_cap, 8'hA5);
    chk("basic_rises", rises, 8);
    chk("basic_busy_len", busy_cnt, 64);
    chk("basic_done_lat", done_cycles[$] - s0, 65);
    chk("basic_byte_out", bus.byte_out, 8'h3C);
    step(1'b0, 8'h00);

    // Busy rejection
    slave_byte = 8'h96;
    step(1'b1, 8'hFF);
    s0 = cyc;
    repeat (9) step(1'b0, 8'h00);
    step(1'b1, 8'h00);
    repeat (XFER + 1 - 10) step(1'b0, 8'h00);
    chk("rej_rises", rises, 8);
    chk("rej_mosi_bits", mosi_cap, 8'hFF);
    chk("rej_done_lat", done_cycles[$] - s0, 65);
    chk("rej_byte_out", bus.byte_out, 8'h96);
    repeat (3) step(1'b0, 8'h00);

    // Back-to-back: second start lands on the DONE cycle
    slave_byte = 8'h5C;
    step(1'b1, 8'h18);
    repeat (XFER) step(1'b0, 8'h00);
    slave_byte = 8'hE7;
    step(1'b1, 8'h81);
    chk("b2b_first_done", bus.byte_out, 8'h5C);
    step(1'b0, 8'h00);
    chk("b2b_second_mosi0", mosi, 1'b1);
    chk("b2b_second_busy", bus.busy, 1'b1);
    repeat (XFER) step(1'b0, 8'h00);
    chk("b2b_done_gap", done_cycles[$] - done_cycles[$-1], 65);
    chk("b2b_mosi_bits", mosi_cap, 8'h81);
    chk("b2b_byte_out", bus.byte_out, 8'hE7);
    repeat (3) step(1'b0, 8'h00);

    // Reset mid-transfer (asynchronous)
    ndone = done_cycles.size();
    slave_byte = 8'h11;
    step(1'b1, 8'hFF);
    repeat (30) step(1'b0, 8'h00);
    chk("pre_rst_sclk", sclk, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_sclk", sclk, 1'b0);
    chk("arst_mosi", mosi, 1'b0);
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_done", bus.done, 1'b0);
    chk("arst_byte_out", bus.byte_out, 8'h00);
    m_active = 1'b0;
    m_bo = 8'h00;
    step(1'b0, 8'h00);
    rst = 1'b0;
    repeat (40) step(1'b0, 8'h00);
    chk("rst_no_done", done_cycles.size(), ndone);
    slave_byte = 8'hA3;
    step(1'b1, 8'h5A);
    repeat (XFER + 1) step(1'b0, 8'h00);
    chk("post_rst_mosi_bits", mosi_cap, 8'h5A);
    chk("post_rst_byte_out", bus.byte_out, 8'hA3);
    chk("post_rst_done_count", done_cycles.size(), ndone + 1);
    repeat (3) step(1'b0, 8'h00);

`ifdef SPI_LOOPBACK_EN
    loopback = 1'b1;
    tie_miso0 = 1'b1;
    slave_byte = 8'h00;
    step(1'b1, 8'hC3);
    repeat (XFER + 1) step(1'b0, 8'h00);
    chk("loopback_byte_out", bus.byte_out, 8'hC3);
    repeat (2) step(1'b0, 8'h00);
    loopback = 1'b0;
    tie_miso0 = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
